// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback-stage register file with result mux, write bypass and commit counter
module wb_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LINK_REG = 31,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              regwritew,
    input  logic              memtoregw,
    input  logic              jumplinkw,
    input  logic [DATA_W-1:0] rdw,
    input  logic [DATA_W-1:0] aluoutw,
    input  logic [ADDR_W-1:0] writeregw,
    input  logic [DATA_W-1:0] pcplus4w,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] resultw,
    output logic [31:0]       commit_cnt
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [31:0]       commit_cnt_q;
    logic [31:0]       commit_cnt_d;
    logic [ADDR_W-1:0] dst;
    logic              we;
    logic              byp_en;

    // Link takes priority so an X on memtoregw cannot leak into a jal/jalr result.
    always_comb begin
        resultw = aluoutw;
        if (jumplinkw) begin
            resultw = pcplus4w;
        end else if (memtoregw) begin
            resultw = rdw;
        end
    end

    assign dst    = jumplinkw ? ADDR_W'(LINK_REG) : writeregw;
    assign we     = (regwritew | jumplinkw) & (dst != '0);
    assign byp_en = (BYPASS != 0) & we & rst_n;

    always_comb begin
        commit_cnt_d = commit_cnt_q;
        if (we) begin
            commit_cnt_d = commit_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            commit_cnt_q <= '0;
        end else begin
            if (we) begin
                regs_q[dst] <= resultw;
            end
            commit_cnt_q <= commit_cnt_d;
        end
    end

    always_comb begin
        rd1 = regs_q[ra1];
        if (ra1 == '0 || !rst_n) begin
            rd1 = '0;
        end else if (byp_en && dst == ra1) begin
            rd1 = resultw;
        end
    end

    always_comb begin
        rd2 = regs_q[ra2];
        if (ra2 == '0 || !rst_n) begin
            rd2 = '0;
        end else if (byp_en && dst == ra2) begin
            rd2 = resultw;
        end
    end

    assign commit_cnt = commit_cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - scoreboard bench for wb_regfile (BYPASS=1 and BYPASS=0 instances)
module tb_wb_regfile;

    logic        clk;
    logic        rst_n;
    logic        regwritew;
    logic        memtoregw;
    logic        jumplinkw;
    logic [31:0] rdw;
    logic [31:0] aluoutw;
    logic [4:0]  writeregw;
    logic [31:0] pcplus4w;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1, rd2, resultw, commit_cnt;
    logic [31:0] rd1_nb, rd2_nb, resultw_nb, commit_cnt_nb;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t sb[$];
    int  tests_run;
    int  tests_failed;

    wb_regfile #(.BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .regwritew(regwritew), .memtoregw(memtoregw),
        .jumplinkw(jumplinkw), .rdw(rdw), .aluoutw(aluoutw), .writeregw(writeregw),
        .pcplus4w(pcplus4w), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .resultw(resultw), .commit_cnt(commit_cnt)
    );

    wb_regfile #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .regwritew(regwritew), .memtoregw(memtoregw),
        .jumplinkw(jumplinkw), .rdw(rdw), .aluoutw(aluoutw), .writeregw(writeregw),
        .pcplus4w(pcplus4w), .ra1(ra1), .ra2(ra2), .rd1(rd1_nb), .rd2(rd2_nb),
        .resultw(resultw_nb), .commit_cnt(commit_cnt_nb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive_idle();
        regwritew = 1'b0;
        memtoregw = 1'b0;
        jumplinkw = 1'b0;
        rdw       = 32'h0;
        aluoutw   = 32'h0;
        writeregw = 5'd0;
        pcplus4w  = 32'h0;
    endtask

    task automatic drive_alu_write(input logic [4:0] a, input logic [31:0] d);
        regwritew = 1'b1;
        memtoregw = 1'b0;
        jumplinkw = 1'b0;
        aluoutw   = d;
        writeregw = a;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        ra1 = 5'd5;
        ra2 = 5'd5;
        @(negedge clk);
        drive_alu_write(5'd5, 32'h55);
        #1;
        tests_run++;
        if (rd1 !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_no_bypass: rd1=%h expected %h", rd1, 32'h0);
        end
        @(negedge clk);
        tests_run++;
        if (commit_cnt !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_no_count: commit_cnt=%h expected %h", commit_cnt, 32'h0);
        end
        drive_idle();
        rst_n = 1'b1;
        @(negedge clk);
        drive_alu_write(5'd5, 32'h1234);
        @(negedge clk);
        drive_idle();
        #1;
        tests_run++;
        if (rd1 !== 32'h1234) begin
            tests_failed++;
            $display("FAIL reset_prewrite: rd1=%h expected %h", rd1, 32'h1234);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (rd1 !== 32'h0 || commit_cnt !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_async: rd1=%h cnt=%h expected 0 0", rd1, commit_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
    endtask

    task automatic test_alu_write();
        wr_t e;
        @(negedge clk);
        drive_alu_write(5'd8, 32'hDEADBEEF);
        sb.push_back('{a: 5'd8, d: 32'hDEADBEEF});
        @(negedge clk);
        drive_idle();
        e = sb.pop_front();
        ra1 = e.a;
        #1;
        tests_run++;
        if (rd1 !== e.d || commit_cnt !== 32'd1) begin
            tests_failed++;
            $display("FAIL alu_write: rd1=%h cnt=%0d expected %h 1", rd1, commit_cnt, e.d);
        end
    endtask

    task automatic test_load_bypass();
        wr_t e;
        @(negedge clk);
        regwritew = 1'b1;
        memtoregw = 1'b1;
        rdw       = 32'hCAFE0001;
        aluoutw   = 32'h11111111;
        writeregw = 5'd9;
        ra1 = 5'd9;
        ra2 = 5'd9;
        sb.push_back('{a: 5'd9, d: 32'hCAFE0001});
        #1;
        tests_run++;
        if (rd1 !== 32'hCAFE0001 || rd2 !== 32'hCAFE0001) begin
            tests_failed++;
            $display("FAIL load_bypass: rd1=%h rd2=%h expected %h", rd1, rd2, 32'hCAFE0001);
        end
        tests_run++;
        if (rd1_nb !== 32'h0 || rd2_nb !== 32'h0) begin
            tests_failed++;
            $display("FAIL load_nobypass_old: rd1=%h rd2=%h expected 0", rd1_nb, rd2_nb);
        end
        @(negedge clk);
        drive_idle();
        e = sb.pop_front();
        ra1 = e.a;
        ra2 = e.a;
        #1;
        tests_run++;
        if (rd1_nb !== e.d || rd2 !== e.d || commit_cnt !== 32'd2) begin
            tests_failed++;
            $display("FAIL load_commit: nb_rd1=%h rd2=%h cnt=%0d expected %h %h 2", rd1_nb, rd2, commit_cnt, e.d, e.d);
        end
    endtask

    task automatic test_link();
        wr_t e;
        @(negedge clk);
        jumplinkw = 1'b1;
        regwritew = 1'b0;
        memtoregw = 1'bx;
        rdw       = 32'hBAD0BAD0;
        aluoutw   = 32'h0BAD0BAD;
        pcplus4w  = 32'h00400010;
        writeregw = 5'd3;
        sb.push_back('{a: 5'd31, d: 32'h00400010});
        #1;
        tests_run++;
        if (resultw !== 32'h00400010) begin
            tests_failed++;
            $display("FAIL link_result: resultw=%h expected %h", resultw, 32'h00400010);
        end
        @(negedge clk);
        drive_idle();
        e = sb.pop_front();
        ra1 = e.a;
        ra2 = 5'd3;
        #1;
        tests_run++;
        if (rd1 !== e.d || rd2 !== 32'h0 || commit_cnt !== 32'd3) begin
            tests_failed++;
            $display("FAIL link_commit: r31=%h r3=%h cnt=%0d expected %h 0 3", rd1, rd2, commit_cnt, e.d);
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        drive_alu_write(5'd0, 32'hFFFFFFFF);
        ra1 = 5'd0;
        #1;
        tests_run++;
        if (rd1 !== 32'h0 || resultw !== 32'hFFFFFFFF) begin
            tests_failed++;
            $display("FAIL zero_before: rd1=%h resultw=%h expected 0 ffffffff", rd1, resultw);
        end
        @(negedge clk);
        drive_idle();
        #1;
        tests_run++;
        if (rd1 !== 32'h0 || commit_cnt !== 32'd3) begin
            tests_failed++;
            $display("FAIL zero_after: rd1=%h cnt=%0d expected 0 3", rd1, commit_cnt);
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        dut.commit_cnt_q = 32'hFFFFFFFF;
        #1;
        tests_run++;
        if (commit_cnt !== 32'hFFFFFFFF) begin
            tests_failed++;
            $display("FAIL wrap_preset: cnt=%h expected ffffffff", commit_cnt);
        end
        drive_alu_write(5'd1, 32'h1);
        @(negedge clk);
        drive_idle();
        #1;
        tests_run++;
        if (commit_cnt !== 32'h0) begin
            tests_failed++;
            $display("FAIL wrap: cnt=%h expected 0", commit_cnt);
        end
    endtask

    task automatic test_back_to_back();
        wr_t e;
        logic [31:0] v;
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            v = $urandom;
            drive_alu_write(i[4:0], v);
            sb.push_back('{a: i[4:0], d: v});
        end
        @(negedge clk);
        drive_idle();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            ra1 = e.a;
            ra2 = e.a;
            #1;
            tests_run++;
            if (rd1 !== e.d || rd2 !== e.d) begin
                tests_failed++;
                $display("FAIL b2b_r%0d: rd1=%h rd2=%h expected %h", e.a, rd1, rd2, e.d);
            end
        end
        tests_run++;
        if (commit_cnt !== 32'd31) begin
            tests_failed++;
            $display("FAIL b2b_count: cnt=%0d expected 31", commit_cnt);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        ra1 = 5'd0;
        ra2 = 5'd0;
        test_reset();
        test_alu_write();
        test_load_bypass();
        test_link();
        test_zero_reg();
        test_wrap();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
